// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter; start, data LSB first, optional parity, stop bits.
// Every bit is held for 16 tx_clk cycles and tx_out is driven straight from a flop.
module uart_tx #(
   parameter int data_width = 8,
   parameter int test       = 2,
   parameter int stop_width = 1
) (
   input  logic                  tx_clk,
   input  logic                  rst_n,
   input  logic [data_width-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx_out,
   output logic                  busy
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic       par_on    = (test == 1) || (test == 2);
   localparam logic [3:0] bit_last  = 4'(data_width - 1);
   localparam logic [1:0] stop_last = 2'(stop_width - 1);
   logic [2:0]            state;
   logic [3:0]            cyc;
   logic [3:0]            bitcnt;
   logic [1:0]            stopcnt;
   logic [data_width-1:0] shreg;
   logic                  par;
   assign tx_ready = state == IDLE;
   assign busy     = !tx_ready;
   // tx_out is loaded with the value of the bit that starts on the same edge
   always_ff @(posedge tx_clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         cyc     <= 4'd0;
         bitcnt  <= 4'd0;
         stopcnt <= 2'd0;
         shreg   <= '0;
         par     <= 1'b0;
         tx_out  <= 1'b1;
      end else if (state == IDLE) begin
         if (tx_valid) begin
            state  <= START;
            shreg  <= tx_data;
            par    <= (test == 1) ? ~^tx_data : ^tx_data;
            tx_out <= 1'b0;
         end
      end else begin
         cyc <= cyc + 4'd1;
         if (cyc == 4'd15)
            case (state)
               START: begin
                  state  <= DATA;
                  tx_out <= shreg[0];
               end
               DATA: begin
                  shreg <= {1'b0, shreg[data_width-1:1]};
                  if (bitcnt == bit_last) begin
                     bitcnt <= 4'd0;
                     state  <= par_on ? PARITY : STOP;
                     tx_out <= par_on ? par : 1'b1;
                  end else begin
                     bitcnt <= bitcnt + 4'd1;
                     tx_out <= shreg[1];
                  end
               end
               PARITY: begin
                  state  <= STOP;
                  tx_out <= 1'b1;
               end
               STOP: begin
                  stopcnt <= (stopcnt == stop_last) ? 2'd0 : stopcnt + 2'd1;
                  state   <= (stopcnt == stop_last) ? IDLE : STOP;
               end
               default: begin
                  state  <= IDLE;
                  tx_out <= 1'b1;
               end
            endcase
      end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four uart_tx instances (even, odd, no parity, two stop bits) checked cycle by
// cycle against a frame model built from bit lists.
module tb_uart_tx;
   typedef logic bq_t [$];
   logic       tx_clk = 1'b0;
   logic       rst_n  = 1'b0;
   logic [7:0] data  [4];
   logic       valid [4];
   logic       ready [4];
   logic       txo   [4];
   logic       bsy   [4];
   int         errors = 0;
   int         checks = 0;
   int         low_cnt, bsy_bad;
   logic       cap [$];
   bq_t        exp_q;
   always #5 tx_clk = ~tx_clk;
   uart_tx #(.test(2)) u0 (.tx_clk(tx_clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(valid[0]),
                           .tx_ready(ready[0]), .tx_out(txo[0]), .busy(bsy[0]));
   uart_tx #(.test(1)) u1 (.tx_clk(tx_clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(valid[1]),
                           .tx_ready(ready[1]), .tx_out(txo[1]), .busy(bsy[1]));
   uart_tx #(.test(0)) u2 (.tx_clk(tx_clk), .rst_n(rst_n), .tx_data(data[2]), .tx_valid(valid[2]),
                           .tx_ready(ready[2]), .tx_out(txo[2]), .busy(bsy[2]));
   uart_tx #(.stop_width(2)) u3 (.tx_clk(tx_clk), .rst_n(rst_n), .tx_data(data[3]), .tx_valid(valid[3]),
                                 .tx_ready(ready[3]), .tx_out(txo[3]), .busy(bsy[3]));
   // line level per cycle: bit list (start, data LSB first, parity, stops) each repeated 16 times
   function automatic bq_t model(input logic [7:0] w, input int pm, input int sw);
      bq_t b, r;
      int  ones = 0;
      b.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         b.push_back(w[i]);
         ones += int'(w[i]);
      end
      if (pm == 1) b.push_back(ones % 2 == 0);
      if (pm == 2) b.push_back(ones % 2 == 1);
      for (int i = 0; i < sw; i++) b.push_back(1'b1);
      foreach (b[i]) repeat (16) r.push_back(b[i]);
      return r;
   endfunction
   task automatic send(input int d, input logic [7:0] w);
      @(negedge tx_clk);
      data[d]  = w;
      valid[d] = 1'b1;
   endtask
   task automatic capture(input int d, input int n, input int drop_at, input int mut_end, input logic [7:0] second);
      cap.delete();
      low_cnt = 0;
      bsy_bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge tx_clk);
         cap.push_back(txo[d]);
         if (!ready[d]) low_cnt++;
         if (bsy[d] !== !ready[d]) bsy_bad++;
         if (i == drop_at) valid[d] = 1'b0;
         if (i < mut_end) data[d] = 8'($urandom);
         if (i == mut_end) data[d] = second;
      end
   endtask
   task automatic test_reset;
      repeat (5) @(negedge tx_clk);
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (txo[d] !== 1'b1 || ready[d] !== 1'b1 || bsy[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset dut%0d: out/ready/busy got %b%b%b want 110", d, txo[d], ready[d], bsy[d]);
         end
      end
      rst_n = 1'b1;
      capture(0, 100, 0, 0, 8'h00);
      foreach (cap[i]) begin
         checks++;
         if (cap[i] !== 1'b1) begin
            errors++;
            $display("FAIL idle_line[%0d]: got %b want 1", i, cap[i]);
         end
      end
      checks++;
      if (low_cnt !== 0) begin
         errors++;
         $display("FAIL idle_ready: low cycles got %0d want 0", low_cnt);
      end
   endtask
   task automatic test_defaults;
      logic [7:0] w;
      for (int k = 0; k < 4; k++) begin
         w = (k == 0) ? 8'hA5 : 8'($urandom);
         exp_q = model(w, 2, 1);
         send(0, w);
         capture(0, 190, 0, 0, w);
         foreach (cap[i]) begin
            checks++;
            if (cap[i] !== ((i < 176) ? exp_q[i] : 1'b1)) begin
               errors++;
               $display("FAIL even_frame %h [%0d]: got %b want %b", w, i, cap[i], (i < 176) ? exp_q[i] : 1'b1);
            end
         end
         checks++;
         if (low_cnt !== 176 || bsy_bad !== 0) begin
            errors++;
            $display("FAIL even_len %h: ready low %0d want 176, busy errs %0d want 0", w, low_cnt, bsy_bad);
         end
      end
   endtask
   task automatic test_parity;
      logic [7:0] w;
      for (int k = 0; k < 3; k++) begin
         w = (k == 0) ? 8'h01 : 8'($urandom);
         exp_q = model(w, 1, 1);
         send(1, w);
         capture(1, 190, 0, 0, w);
         foreach (cap[i]) begin
            checks++;
            if (cap[i] !== ((i < 176) ? exp_q[i] : 1'b1)) begin
               errors++;
               $display("FAIL odd_frame %h [%0d]: got %b want %b", w, i, cap[i], (i < 176) ? exp_q[i] : 1'b1);
            end
         end
         checks++;
         if (low_cnt !== 176) begin
            errors++;
            $display("FAIL odd_len %h: ready low %0d want 176", w, low_cnt);
         end
         w = 8'($urandom);
         exp_q = model(w, 0, 1);
         send(2, w);
         capture(2, 175, 0, 0, w);
         foreach (cap[i]) begin
            checks++;
            if (cap[i] !== ((i < 160) ? exp_q[i] : 1'b1)) begin
               errors++;
               $display("FAIL nopar_frame %h [%0d]: got %b want %b", w, i, cap[i], (i < 160) ? exp_q[i] : 1'b1);
            end
         end
         checks++;
         if (low_cnt !== 160) begin
            errors++;
            $display("FAIL nopar_len %h: ready low %0d want 160", w, low_cnt);
         end
      end
   endtask
   task automatic test_back_to_back;
      bq_t second_q;
      exp_q = model(8'h55, 2, 2);
      second_q = model(8'hAA, 2, 2);
      exp_q.push_back(1'b1);
      foreach (second_q[i]) exp_q.push_back(second_q[i]);
      send(3, 8'h55);
      capture(3, 405, 193, 150, 8'hAA);
      foreach (cap[i]) begin
         checks++;
         if (cap[i] !== ((i < 385) ? exp_q[i] : 1'b1)) begin
            errors++;
            $display("FAIL b2b_frame [%0d]: got %b want %b", i, cap[i], (i < 385) ? exp_q[i] : 1'b1);
         end
      end
      checks++;
      if (low_cnt !== 384 || bsy_bad !== 0) begin
         errors++;
         $display("FAIL b2b_len: ready low %0d want 384, busy errs %0d want 0", low_cnt, bsy_bad);
      end
   endtask
   task automatic test_reset_mid;
      send(0, 8'hF0);
      capture(0, 70, 0, 0, 8'hF0);
      checks++;
      if (cap[69] !== 1'b0 || ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_bit3: out/ready got %b%b want 00", cap[69], ready[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (txo[0] !== 1'b1 || ready[0] !== 1'b1 || bsy[0] !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: out/ready/busy got %b%b%b want 110", txo[0], ready[0], bsy[0]);
      end
      @(negedge tx_clk);
      rst_n = 1'b1;
      exp_q = model(8'h3C, 2, 1);
      send(0, 8'h3C);
      capture(0, 185, 0, 0, 8'h3C);
      foreach (cap[i]) begin
         checks++;
         if (cap[i] !== ((i < 176) ? exp_q[i] : 1'b1)) begin
            errors++;
            $display("FAIL post_reset_frame [%0d]: got %b want %b", i, cap[i], (i < 176) ? exp_q[i] : 1'b1);
         end
      end
      checks++;
      if (low_cnt !== 176) begin
         errors++;
         $display("FAIL post_reset_len: ready low %0d want 176", low_cnt);
      end
   endtask
   task automatic test_data_change;
      logic [7:0] w;
      for (int k = 0; k < 2; k++) begin
         w = 8'($urandom);
         exp_q = model(w, 2, 1);
         send(0, w);
         capture(0, 180, 0, 179, 8'h00);
         foreach (cap[i]) begin
            checks++;
            if (cap[i] !== ((i < 176) ? exp_q[i] : 1'b1)) begin
               errors++;
               $display("FAIL latched_word %h [%0d]: got %b want %b", w, i, cap[i], (i < 176) ? exp_q[i] : 1'b1);
            end
         end
      end
   endtask
   initial begin
      for (int d = 0; d < 4; d++) begin
         data[d]  = 8'h00;
         valid[d] = 1'b0;
      end
      test_reset;
      test_defaults;
      test_parity;
      test_back_to_back;
      test_reset_mid;
      test_data_change;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
